// File: rtl/spio_edvs_pkg.sv
// Shared definitions for the eDVS packet path: packet width, field offsets
// inside the 72-bit packet, and the source-port tag helper.
package spio_edvs_pkg;

    localparam int unsigned PKT_BITS      = 72;

    // packet field layout
    localparam int unsigned HDR_LSB       = 0;
    localparam int unsigned HDR_MSB       = 7;
    localparam int unsigned POL_BIT       = 8;
    localparam int unsigned X_LSB         = 9;
    localparam int unsigned X_MSB         = 15;
    localparam int unsigned Y_LSB         = 24;
    localparam int unsigned Y_MSB         = 31;
    localparam int unsigned KEY_SRC_LSB   = 32;
    localparam int unsigned KEY_SRC_MSB   = 39;
    localparam int unsigned TS_LSB        = 40;
    localparam int unsigned TS_MSB        = 55;

    localparam int unsigned SRC_BITS      = KEY_SRC_MSB - KEY_SRC_LSB + 1;

    // port indices are carried in 3 bits (up to 8 sources)
    localparam int unsigned MAX_PORTS     = 8;
    localparam int unsigned PORT_IDX_BITS = 3;

    typedef logic [PKT_BITS-1:0]      pkt_t;
    typedef logic [PORT_IDX_BITS-1:0] port_idx_t;

    // port index zero-extended into the routing-key source field
    function automatic logic [SRC_BITS-1:0] src_tag(input port_idx_t port);
        return SRC_BITS'(port);
    endfunction

endpackage

// File: rtl/spio_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after i_last, wrapping back to 0.
module spio_rr_pick
    import spio_edvs_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  port_idx_t            i_last,
    output port_idx_t            o_grant,
    output logic                 o_any
);

    // two ordered scans avoid a variable modulo: indices above i_last first,
    // then the wrapped range 0..i_last
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (!o_any && i_req[j] && (32'(i_last) < j)) begin
                o_grant = port_idx_t'(j);
                o_any   = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (!o_any && i_req[j]) begin
                o_grant = port_idx_t'(j);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spio_edvs_link_arbiter.sv
// Round-robin arbiter sharing one SpiNNaker link transmitter between several
// eDVS packet sources. One whole packet is forwarded per grant through a
// registered output stage; per-port saturating counters track forwarded packets.
module spio_edvs_link_arbiter
    import spio_edvs_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned WORD_SIZE  = 72,
    parameter int unsigned TAG_SOURCE = 1,
    parameter int unsigned COUNT_BITS = 16
) (
    input  logic                            CLK_IN,
    input  logic                            RESET_IN,
    input  logic [NUM_PORTS-1:0]            PORT_EN_IN,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]  IN_DATA_IN,
    input  logic [NUM_PORTS-1:0]            IN_VLD_IN,
    output logic [NUM_PORTS-1:0]            IN_RDY_OUT,
    output logic [WORD_SIZE-1:0]            OUT_DATA_OUT,
    output logic                            OUT_VLD_OUT,
    input  logic                            OUT_RDY_IN,
    output logic [2:0]                      GRANT_OUT,
    output logic [NUM_PORTS*COUNT_BITS-1:0] COUNT_OUT
);

    logic [NUM_PORTS-1:0]  w_req;
    logic [NUM_PORTS-1:0]  w_onehot;
    port_idx_t             w_grant;
    logic                  w_any;
    logic                  w_slot_free;
    logic                  w_take;
    logic [WORD_SIZE-1:0]  w_sel_data;
    logic [WORD_SIZE-1:0]  w_fwd_data;

    logic                  r_out_vld;
    logic [WORD_SIZE-1:0]  r_out_data;
    port_idx_t             r_grant;
    port_idx_t             r_last;
    logic [COUNT_BITS-1:0] r_count [NUM_PORTS];

    assign w_req       = IN_VLD_IN & PORT_EN_IN;
    assign w_slot_free = !r_out_vld || OUT_RDY_IN;
    // no handshake is offered while reset is asserted
    assign w_take      = RESET_IN && w_slot_free && w_any;

    spio_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // select the granted packet and optionally stamp its source index
    always_comb begin
        w_onehot   = '0;
        w_sel_data = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_grant == port_idx_t'(p)) begin
                w_onehot[p] = 1'b1;
                w_sel_data  = IN_DATA_IN[p*WORD_SIZE +: WORD_SIZE];
            end
        end
        w_fwd_data = w_sel_data;
        if (TAG_SOURCE != 0) begin
            w_fwd_data[KEY_SRC_MSB:KEY_SRC_LSB] = src_tag(w_grant);
        end
    end

    assign IN_RDY_OUT = w_take ? w_onehot : '0;

    // output register: load on handshake, drain when consumed with no request
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_grant    <= '0;
            r_last     <= port_idx_t'(NUM_PORTS - 1);
        end else if (w_slot_free) begin
            if (w_any) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_fwd_data;
                r_grant    <= w_grant;
                r_last     <= w_grant;
            end else begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    // per-port forwarded-packet counters, saturating at all-ones
    always_ff @(posedge CLK_IN) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (!RESET_IN) begin
                r_count[p] <= '0;
            end else if (w_take && (w_grant == port_idx_t'(p)) && (r_count[p] != '1)) begin
                r_count[p] <= r_count[p] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_count_out
        assign COUNT_OUT[g*COUNT_BITS +: COUNT_BITS] = r_count[g];
    end

    assign OUT_VLD_OUT  = r_out_vld;
    assign OUT_DATA_OUT = r_out_data;
    assign GRANT_OUT    = r_grant;

endmodule

// File: tb/tb_spio_edvs_link_arbiter.sv
// Directed bench for the eDVS link arbiter (2 ports, 4-bit counters, tagging on).
// Accepted packets are pushed to a scoreboard queue and popped as the link side
// consumes them; a small round-robin model predicts every handshake.
module tb_spio_edvs_link_arbiter;

    localparam int unsigned NP = 2;
    localparam int unsigned WS = 72;
    localparam int unsigned CB = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP-1:0]      en;
    logic [NP*WS-1:0]   in_data;
    logic [NP-1:0]      vld;
    logic [NP-1:0]      in_rdy;
    logic [WS-1:0]      out_data;
    logic               out_vld;
    logic               out_rdy;
    logic [2:0]         grant;
    logic [NP*CB-1:0]   count;

    spio_edvs_link_arbiter #(
        .NUM_PORTS  (NP),
        .WORD_SIZE  (WS),
        .TAG_SOURCE (1),
        .COUNT_BITS (CB)
    ) dut (
        .CLK_IN       (clk),
        .RESET_IN     (rst_n),
        .PORT_EN_IN   (en),
        .IN_DATA_IN   (in_data),
        .IN_VLD_IN    (vld),
        .IN_RDY_OUT   (in_rdy),
        .OUT_DATA_OUT (out_data),
        .OUT_VLD_OUT  (out_vld),
        .OUT_RDY_IN   (out_rdy),
        .GRANT_OUT    (grant),
        .COUNT_OUT    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WS-1:0] pkt;
        logic [2:0]    gnt;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;

    // bench model state
    logic          m_vld;
    logic [2:0]    m_last;
    logic [CB-1:0] m_cnt [NP];
    int unsigned   seq [NP];

    function automatic logic [WS-1:0] make_pkt(input int unsigned p, input int unsigned s);
        return {8'h5A, 16'hD000 + 16'(s), 8'hC3 + 8'(s), 8'h30 + 8'(p),
                16'(s * 7) ^ 16'h1234, 8'h80 + 8'(p), 8'hE5};
    endfunction

    task automatic drive_data();
        in_data = {make_pkt(1, seq[1]), make_pkt(0, seq[0])};
    endtask

    task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vld  = 1'b0;
        m_last = 3'(NP - 1);
        for (int i = 0; i < NP; i++) m_cnt[i] = '0;
        sb.delete();
    endtask

    // one clock: predict at the falling edge, compare, advance the model
    task automatic cycle();
        logic [NP-1:0] req;
        logic [NP-1:0] exp_rdy;
        logic          free;
        logic          any;
        logic [2:0]    g;
        exp_t          e;
        @(negedge clk);
        req  = vld & en;
        free = !m_vld || out_rdy;
        any  = 1'b0;
        g    = '0;
        for (int i = 1; i <= NP; i++) begin
            int idx;
            idx = (int'(m_last) + i) % NP;
            if (!any && req[idx]) begin
                g   = 3'(idx);
                any = 1'b1;
            end
        end
        exp_rdy = (rst_n && free && any) ? NP'(1) << g : '0;
        chk("in_rdy", WS'(in_rdy), WS'(exp_rdy));
        chk("out_vld", WS'(out_vld), WS'(m_vld));
        if (m_vld) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", WS'(1), WS'(0));
            end else begin
                chk("out_data", out_data, sb[0].pkt);
                chk("grant", WS'(grant), WS'(sb[0].gnt));
            end
        end
        chk("count", WS'(count), WS'({m_cnt[1], m_cnt[0]}));
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_vld && out_rdy && sb.size() != 0) void'(sb.pop_front());
            if (free) begin
                if (any) begin
                    e.pkt = make_pkt(g, seq[g]);
                    e.pkt[39:32] = 8'(g);
                    e.gnt = g;
                    sb.push_back(e);
                    m_vld  = 1'b1;
                    m_last = g;
                    if (m_cnt[g] != '1) m_cnt[g] = m_cnt[g] + 1'b1;
                    seq[g]++;
                end else begin
                    m_vld = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        drive_data();
    endtask

    initial begin
        seq[0] = 0;
        seq[1] = 0;
        rst_n   = 1'b0;
        en      = 2'b11;
        vld     = 2'b11;
        out_rdy = 1'b1;
        drive_data();
        model_reset();
        @(posedge clk);
        #1;

        // reset held with both ports valid
        repeat (3) cycle();
        chk("rst_data", out_data, '0);
        chk("rst_grant", WS'(grant), WS'(0));

        // fairness: strict alternation starting at port 0
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("fair_gnt", WS'(grant), WS'(i % 2));
            chk("fair_key", WS'(out_data[39:32]), WS'(i % 2));
        end
        chk("fair_cnt", WS'(count), WS'({4'd4, 4'd4}));

        // back-pressure: held packet stays put, nothing accepted
        out_rdy = 1'b0;
        repeat (5) cycle();
        out_rdy = 1'b1;
        repeat (3) cycle();

        // enable mask: only port 1 served
        en = 2'b10;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("mask_gnt", WS'(grant), WS'(1));
        end
        en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("unmask_gnt", WS'(grant), WS'(i % 2));
        end

        // saturation: 20 packets from port 0
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        en = 2'b01;
        repeat (20) cycle();
        chk("sat_cnt0", WS'(count[3:0]), WS'(4'hF));
        chk("sat_cnt1", WS'(count[7:4]), WS'(4'h0));

        // reset mid-transfer with the packet held
        en = 2'b11;
        out_rdy = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        chk("midrst_vld", WS'(out_vld), WS'(0));
        chk("midrst_cnt", WS'(count), WS'(0));
        rst_n = 1'b1;
        out_rdy = 1'b1;
        repeat (3) cycle();

        // idle: all sources empty, output drains
        vld = 2'b00;
        repeat (3) cycle();
        chk("idle_vld", WS'(out_vld), WS'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
